// File: rtl/rv32_mod_bus_arbiter.sv
// Round-robin arbiter sharing one req/ack/err memory port between instruction fetch and
// load/store, with a per-grant timeout so a silent slave cannot stall the core.
module rv32_mod_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_W      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e               state_q, state_d;
  logic                 last_data_q, last_data_d;  // 1: data port held the most recent grant
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout;

  assign instr_data_o = mem_data_i;
  assign data_data_o  = mem_data_i;

  // TIMEOUT_CYCLES == 0 disables the timeout entirely.
  assign timeout = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    cnt_d       = cnt_q;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_be      = 4'h0;
    mem_addr    = 32'h0;
    mem_data_o  = 32'h0;
    instr_ack   = 1'b0;
    instr_err   = 1'b0;
    data_ack    = 1'b0;
    data_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_req && (!instr_req || !last_data_q)) begin
          state_d     = StGntD;
          last_data_d = 1'b1;
          cnt_d       = '0;
        end else if (instr_req) begin
          state_d     = StGntI;
          last_data_d = 1'b0;
          cnt_d       = '0;
        end
      end
      StGntI: begin
        mem_req  = 1'b1;
        mem_addr = instr_addr;
        mem_be   = 4'hF;
        cnt_d    = cnt_q + 1'b1;
        // Error beats ack when the slave raises both.
        if (mem_err || (!mem_ack && timeout)) begin
          instr_err = 1'b1;
          state_d   = StIdle;
        end else if (mem_ack) begin
          instr_ack = 1'b1;
          state_d   = StIdle;
        end
      end
      StGntD: begin
        mem_req    = 1'b1;
        mem_addr   = data_addr;
        mem_wr     = data_wr;
        mem_be     = data_be;
        mem_data_o = data_data_i;
        cnt_d      = cnt_q + 1'b1;
        if (mem_err || (!mem_ack && timeout)) begin
          data_err = 1'b1;
          state_d  = StIdle;
        end else if (mem_ack) begin
          data_ack = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Randomised bench for rv32_mod_bus_arbiter: transaction-level grant model plus a response
// scoreboard drained by an independent monitor.
module tb_rv32_mod_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, instr_ack, instr_err;
  logic [31:0] instr_addr, instr_data_o;
  logic        data_req, data_wr, data_ack, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_data_i, data_data_o;
  logic        mem_req, mem_wr, mem_ack, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_data_o, mem_data_i;

  rv32_mod_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_ack   (instr_ack),
    .instr_err   (instr_err),
    .instr_data_o(instr_data_o),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_data_i (data_data_i),
    .data_ack    (data_ack),
    .data_err    (data_err),
    .data_data_o (data_data_o),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_data_o  (mem_data_o),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err),
    .mem_data_i  (mem_data_i)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          who;   // 1 = instr, 2 = data
    bit          err;
    logic [31:0] data;
    int          cyc;
  } resp_t;
  resp_t sb[$];

  int checks = 0;
  int fails  = 0;

  // Requester intent and the transaction-level model of who owns the port.
  logic        pi, pd, dw;
  logic [31:0] ia, da, dd;
  logic [3:0]  dbe;
  int          owner, prev_owner, last_g, age, lat, kind;
  bit          prev_done, snap_i, snap_d;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    instr_req   = pi;
    instr_addr  = ia;
    data_req    = pd;
    data_wr     = dw;
    data_be     = dbe;
    data_addr   = da;
    data_data_i = dd;
  endtask

  // One clock cycle: predict the owner, check the memory side, play the slave, update requesters.
  task automatic step(input bit allow_new);
    bit          done;
    logic [69:0] exp_mem;
    logic [31:0] rd;
    @(posedge clk);
    #1;
    if (prev_owner != 0) owner = prev_done ? 0 : prev_owner;
    else if (snap_i && snap_d) owner = (last_g == 1) ? 2 : 1;
    else if (snap_d) owner = 2;
    else if (snap_i) owner = 1;
    else owner = 0;
    if (owner != 0 && prev_owner == 0) begin
      last_g = owner;
      age    = 0;
      lat    = $urandom_range(0, TO - 1);
      kind   = $urandom_range(0, 7);
    end

    case (owner)
      1:       exp_mem = {1'b1, 1'b0, 4'hF, ia, 32'h0};
      2:       exp_mem = {1'b1, dw, dbe, da, dd};
      default: exp_mem = '0;
    endcase
    chk("mem_port", 96'({mem_req, mem_wr, mem_be, mem_addr, mem_data_o}), 96'(exp_mem));

    rd         = $urandom;
    mem_data_i = rd;
    mem_ack    = 1'b0;
    mem_err    = 1'b0;
    done       = 1'b0;
    if (owner != 0) begin
      // kind 0-3 ack, 4 err, 5 ack+err, 6-7 silent slave
      if (kind < 6 && age == lat) begin
        mem_ack = (kind != 4);
        mem_err = (kind >= 4);
        sb.push_back('{who: owner, err: (kind >= 4), data: rd, cyc: cyc});
        done = 1'b1;
      end else if (age == TO - 1) begin
        sb.push_back('{who: owner, err: 1'b1, data: 32'h0, cyc: cyc});
        done = 1'b1;
      end
      age++;
    end else begin
      // Stray responses while idle (including late acks after a timeout) must be ignored.
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_err = ($urandom_range(0, 5) == 0);
    end

    if (prev_done && prev_owner == 1) pi = 1'b0;
    if (prev_done && prev_owner == 2) pd = 1'b0;
    if (allow_new && !pi && $urandom_range(0, 2) != 0) begin
      pi = 1'b1;
      ia = $urandom;
    end
    if (allow_new && !pd && $urandom_range(0, 2) != 0) begin
      pd  = 1'b1;
      da  = $urandom;
      dd  = $urandom;
      dw  = 1'($urandom_range(0, 1));
      dbe = 4'($urandom_range(0, 15));
    end
    drive_reqs();

    prev_owner = owner;
    prev_done  = done;
    snap_i     = pi;
    snap_d     = pd;
  endtask

  task automatic model_reset();
    prev_owner = 0;
    prev_done  = 1'b0;
    last_g     = 1;
    snap_i     = pi;
    snap_d     = pd;
  endtask

  task automatic drain();
    int k = 0;
    while ((pi || pd || prev_owner != 0) && k < 100) begin
      step(1'b0);
      k++;
    end
    chk("drain_bound", 96'(k < 100), 96'(1));
  endtask

  // Monitor: every ack/err pulse must match the oldest expected response, in the same cycle.
  initial begin
    logic [3:0]  pat, exp_pat;
    logic [31:0] got_d, exp_d;
    resp_t       e;
    forever begin
      @(negedge clk);
      pat = {instr_ack, instr_err, data_ack, data_err};
      if (!reset && pat != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 96'(pat), 96'(0));
        end else begin
          e       = sb.pop_front();
          exp_pat = (e.who == 1) ? (e.err ? 4'b0100 : 4'b1000) : (e.err ? 4'b0001 : 4'b0010);
          got_d   = e.err ? 32'h0 : ((e.who == 1) ? instr_data_o : data_data_o);
          exp_d   = e.err ? 32'h0 : e.data;
          chk("resp", 96'({pat, got_d, 32'(cyc)}), 96'({exp_pat, exp_d, 32'(e.cyc)}));
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    mem_ack    = 1'b0;
    mem_err    = 1'b0;
    mem_data_i = 32'h0;
    pi  = 1'b0;
    pd  = 1'b0;
    ia  = 32'h0;
    da  = 32'h0;
    dd  = 32'h0;
    dw  = 1'b0;
    dbe = 4'h0;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 96'({mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
                            instr_ack, instr_err, data_ack, data_err}), 96'(0));

    // Both requesters rise together straight out of reset: data must win.
    reset = 1'b0;
    pi  = 1'b1;
    ia  = 32'h0000_0100;
    pd  = 1'b1;
    da  = 32'h1000_0004;
    dd  = 32'hDEAD_BEEF;
    dw  = 1'b1;
    dbe = 4'b0011;
    drive_reqs();
    model_reset();

    repeat (3000) step(1'b1);
    drain();

    // Asynchronous reset in the middle of a data grant.
    mem_ack = 1'b0;
    mem_err = 1'b0;
    @(posedge clk);
    #1;
    pd  = 1'b1;
    da  = 32'h2000_0010;
    dd  = 32'h1234_5678;
    dw  = 1'b0;
    dbe = 4'hF;
    drive_reqs();
    @(posedge clk);
    #1;
    chk("gnt_d_before_reset", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h2000_0010}));
    #2;
    reset = 1'b1;
    #1;
    chk("reset_mid_grant", 96'({mem_req, mem_addr, instr_ack, instr_err, data_ack, data_err}),
        96'(0));
    pi = 1'b1;
    ia = 32'h0000_0200;
    drive_reqs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drain();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 96'(sb.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
